// File: rtl/aexm_dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : aexm_dcache_responder
//  Purpose  : Data-cache side of the CPU<->dcache command interface.
//             Direct-mapped, write-through, no write-allocate. Load misses
//             fill a whole line over a single-outstanding req/ack memory
//             port. Every store is written through as one word.
//  Options  : `define AEXM_DCACHE_STATS_EN to add saturating hit, miss and
//             write counters (stat_hits, stat_misses, stat_writes).
//  Revision : 1.0  initial release
// ============================================================================
module aexm_dcache_responder #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int LINE_W  = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              dcache_enable,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [31:0]       dcache_wdata,
  input  logic [3:0]        dcache_sel,
  output logic              dcache_busy,
  output logic [31:0]       dcache_rdata,
  output logic              dcache_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_sel,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
`ifdef AEXM_DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writes
`endif
);

  // Address field boundaries (byte address, word aligned)
  localparam int c_IDX_LO = LINE_W + 2;
  localparam int c_TAG_LO = INDEX_W + LINE_W + 2;
  localparam int c_TAG_W  = ADDR_W - c_TAG_LO;
  localparam int c_AW     = INDEX_W + LINE_W;
  localparam int c_LINES  = 2**INDEX_W;
  localparam int c_WORDS  = 2**c_AW;
  localparam logic [ADDR_W-1:0] c_WORD_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic [31:0]         r_data  [0:c_WORDS-1];
  logic [c_TAG_W-1:0]  r_tag   [0:c_LINES-1];
  logic [c_LINES-1:0]  r_valid;
  logic [INDEX_W-1:0]  r_idx;
  logic [LINE_W-1:0]   r_off;
  logic [c_TAG_W-1:0]  r_req_tag;
  logic [LINE_W-1:0]   r_fill_cnt;
  logic [31:0]         r_capt;

  logic [LINE_W-1:0]   w_off;
  logic [INDEX_W-1:0]  w_idx;
  logic [c_TAG_W-1:0]  w_tag;
  logic                w_hit;
  logic                w_accept;
  logic                w_last_beat;
  logic [31:0]         w_hit_word;
  logic                w_arr_we;
  logic [c_AW-1:0]     w_arr_addr;
  logic [31:0]         w_arr_wdata;
  logic [3:0]          w_arr_be;
  logic                w_tag_we;
  logic                w_unused_addr;

  assign w_off       = dcache_addr[c_IDX_LO-1:2];
  assign w_idx       = dcache_addr[c_TAG_LO-1:c_IDX_LO];
  assign w_tag       = dcache_addr[ADDR_W-1:c_TAG_LO];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_word  = r_data[{w_idx, w_off}];
  // Commands are only looked at while idle; the CPU keeps one outstanding
  assign w_accept    = (r_state == S_IDLE) && !dcache_busy && dcache_enable;
  assign w_last_beat = (r_fill_cnt == {LINE_W{1'b1}});
  // Byte offset bits carry no meaning for word accesses
  assign w_unused_addr = ^dcache_addr[1:0];

  // Single write port into the line store: store-hit byte merge or fill beat
  always_comb begin
    w_arr_we    = 1'b0;
    w_arr_addr  = {w_idx, w_off};
    w_arr_wdata = dcache_wdata;
    w_arr_be    = dcache_sel;
    if (!rst) begin
      if (w_accept && dcache_we && w_hit) begin
        w_arr_we = 1'b1;
      end else if ((r_state == S_FILL) && mem_ack) begin
        w_arr_we    = 1'b1;
        w_arr_addr  = {r_idx, r_fill_cnt};
        w_arr_wdata = mem_rdata;
        w_arr_be    = 4'hF;
      end
    end
  end

  // Tag is only rewritten when the final beat of a fill lands
  assign w_tag_we = !rst && (r_state == S_FILL) && mem_ack && w_last_beat;

  // Line data and tag storage; validity is tracked separately so no reset
  always_ff @(posedge CLK) begin
    if (w_arr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_arr_be[b]) begin
          r_data[w_arr_addr][8*b +: 8] <= w_arr_wdata[8*b +: 8];
        end
      end
    end
    if (w_tag_we) begin
      r_tag[r_idx] <= r_req_tag;
    end
  end

  // Command FSM with registered CPU and memory-side outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state       <= S_IDLE;
      dcache_busy   <= 1'b0;
      dcache_rdata  <= 32'd0;
      dcache_rvalid <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'd0;
      mem_sel       <= 4'd0;
      r_valid       <= '0;
      r_idx         <= '0;
      r_off         <= '0;
      r_req_tag     <= '0;
      r_fill_cnt    <= '0;
      r_capt        <= 32'd0;
    end else begin
      dcache_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx     <= w_idx;
            r_off     <= w_off;
            r_req_tag <= w_tag;
            if (dcache_we) begin
              r_state     <= S_WRITE;
              dcache_busy <= 1'b1;
              mem_req     <= 1'b1;
              mem_we      <= 1'b1;
              mem_addr    <= {dcache_addr[ADDR_W-1:2], 2'b00};
              mem_wdata   <= dcache_wdata;
              mem_sel     <= dcache_sel;
            end else if (w_hit) begin
              dcache_rdata  <= w_hit_word;
              dcache_rvalid <= 1'b1;
            end else begin
              // Line is being overwritten, so it must not look valid meanwhile
              r_state        <= S_FILL;
              dcache_busy    <= 1'b1;
              mem_req        <= 1'b1;
              mem_we         <= 1'b0;
              mem_addr       <= {dcache_addr[ADDR_W-1:c_IDX_LO], {c_IDX_LO{1'b0}}};
              r_fill_cnt     <= '0;
              r_valid[w_idx] <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
            mem_addr   <= mem_addr + c_WORD_STEP;
            if (r_fill_cnt == r_off) begin
              r_capt <= mem_rdata;
            end
            if (w_last_beat) begin
              r_state        <= S_IDLE;
              dcache_busy    <= 1'b0;
              mem_req        <= 1'b0;
              dcache_rvalid  <= 1'b1;
              dcache_rdata   <= (r_fill_cnt == r_off) ? mem_rdata : r_capt;
              r_valid[r_idx] <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_state     <= S_IDLE;
            dcache_busy <= 1'b0;
            mem_req     <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AEXM_DCACHE_STATS_EN
  // Saturating event counters, updated for each accepted command
  always_ff @(posedge CLK) begin
    if (rst) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
      stat_writes <= 32'd0;
    end else if (w_accept) begin
      if (dcache_we) begin
        if (stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
      end else if (w_hit) begin
        if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aexm_dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aexm_dcache_responder
//  Purpose  : Scoreboard bench for aexm_dcache_responder. A plain memory
//             model predicts load data, a tag table predicts hit/miss, and
//             a randomly acking memory responder checks every beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aexm_dcache_responder;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 6;
  localparam int LINE_W  = 2;
  localparam int BEATS   = 1 << LINE_W;
  localparam int IDX_LO  = LINE_W + 2;
  localparam int TAG_LO  = INDEX_W + LINE_W + 2;
  localparam int LINES   = 1 << INDEX_W;

  logic              CLK = 1'b0;
  logic              rst;
  logic              dcache_enable;
  logic              dcache_we;
  logic [ADDR_W-1:0] dcache_addr;
  logic [31:0]       dcache_wdata;
  logic [3:0]        dcache_sel;
  logic              dcache_busy;
  logic [31:0]       dcache_rdata;
  logic              dcache_rvalid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_sel;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
`ifdef AEXM_DCACHE_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
  logic [31:0]       stat_writes;
`endif

  aexm_dcache_responder #(
    .ADDR_W (ADDR_W),
    .INDEX_W(INDEX_W),
    .LINE_W (LINE_W)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .dcache_enable(dcache_enable),
    .dcache_we    (dcache_we),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_sel   (dcache_sel),
    .dcache_busy  (dcache_busy),
    .dcache_rdata (dcache_rdata),
    .dcache_rvalid(dcache_rvalid),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_sel      (mem_sel),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
`ifdef AEXM_DCACHE_STATS_EN
    ,
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses),
    .stat_writes  (stat_writes)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory models ----------------
  logic [31:0] phys_mem [int unsigned];  // what the DUT actually wrote
  logic [31:0] ref_mem  [int unsigned];  // what the program order says
  bit          ref_valid [0:LINES-1];
  int unsigned ref_tag   [0:LINES-1];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } beat_t;

  beat_t       exp_beat_q [$];
  logic [31:0] exp_load_q [$];

  // ---------------- memory responder ----------------
  int ack_budget = -1;   // -1 unlimited, otherwise acks still allowed
  int acks_seen  = 0;

  always @(negedge CLK) begin : p_resp
    beat_t b;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req === 1'b1) begin
      if (ack_budget != 0 && $urandom_range(0, 1) == 1) begin
        if (ack_budget > 0) ack_budget--;
        mem_ack = 1'b1;
        check("mem_traffic_expected", 32'(exp_beat_q.size() != 0), 32'd1);
        if (exp_beat_q.size() != 0) begin
          b = exp_beat_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(b.we));
          check("mem_addr", mem_addr, b.addr);
          if (b.we) begin
            check("mem_wdata", mem_wdata, b.data);
            check("mem_sel", 32'(mem_sel), 32'(b.sel));
            phys_mem[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_sel);
          end else begin
            mem_rdata = phys_rd(mem_addr);
          end
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;  // stray ack while idle must be ignored
    end
  end

  always @(posedge CLK) if (mem_ack && mem_req) acks_seen++;

  // ---------------- load-data monitor ----------------
  always @(negedge CLK) begin
    if (dcache_rvalid === 1'b1) begin
      check("rvalid_expected", 32'(exp_load_q.size() != 0), 32'd1);
      if (exp_load_q.size() != 0) check("load_rdata", dcache_rdata, exp_load_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> IDX_LO) & (LINES - 1));
  endfunction

  // Issue one command at a negedge and return at the negedge where the DUT is idle again.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] sel, input bit poke);
    int          idx;
    int unsigned tag;
    logic [31:0] wa;
    logic [31:0] base;
    bit          hit;
    beat_t       b;
    idx  = idx_of(addr);
    tag  = addr >> TAG_LO;
    wa   = {addr[31:2], 2'b00};
    base = wa & ~32'(BEATS * 4 - 1);
    hit  = ref_valid[idx] && (ref_tag[idx] == tag);
    if (we) begin
      b = '{we: 1'b1, addr: wa, data: wd, sel: sel};
      exp_beat_q.push_back(b);
      ref_mem[wa] = merge(ref_rd(wa), wd, sel);
    end else begin
      exp_load_q.push_back(ref_rd(wa));
      if (!hit) begin
        for (int k = 0; k < BEATS; k++) begin
          b = '{we: 1'b0, addr: base + 32'(4 * k), data: 32'd0, sel: 4'd0};
          exp_beat_q.push_back(b);
        end
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
      end
    end
    dcache_enable = 1'b1;
    dcache_we     = we;
    dcache_addr   = addr;
    dcache_wdata  = wd;
    dcache_sel    = sel;
    @(negedge CLK);
    dcache_enable = 1'b0;
    if (!we && hit) begin
      check("hit_busy", 32'(dcache_busy), 32'd0);
      check("hit_rvalid", 32'(dcache_rvalid), 32'd1);
      check("hit_no_req", 32'(mem_req), 32'd0);
    end else begin
      check("cmd_busy", 32'(dcache_busy), 32'd1);
      if (poke) begin
        dcache_enable = 1'b1;
        dcache_we     = 1'($urandom);
        dcache_addr   = $urandom;
        dcache_wdata  = $urandom;
        dcache_sel    = 4'($urandom);
        @(negedge CLK);
        dcache_enable = 1'b0;
      end
      for (int c = 0; c < 400 && dcache_busy === 1'b1; c++) @(negedge CLK);
      check("busy_release", 32'(dcache_busy), 32'd0);
      check("done_rvalid", 32'(dcache_rvalid), 32'(!we));
      check("done_req_drop", 32'(mem_req), 32'd0);
    end
  endtask

  task automatic clear_ref_valid();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [31:0] ra;
    clear_ref_valid();
    rst           = 1'b1;
    dcache_enable = 1'b0;
    dcache_we     = 1'b0;
    dcache_addr   = '0;
    dcache_wdata  = '0;
    dcache_sel    = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(dcache_busy), 32'd0);
    check("rst_rvalid", 32'(dcache_rvalid), 32'd0);
    check("rst_rdata", dcache_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_sel", 32'(mem_sel), 32'd0);
    rst = 1'b0;

    // Directed scenarios
    issue(1'b0, 32'h100, 32'd0, 4'd0, 1'b0);          // cold miss, fill 0x100..0x10C
    issue(1'b0, 32'h104, 32'd0, 4'd0, 1'b0);          // hit, beat 1
    issue(1'b1, 32'h104, 32'hAABB_CCDD, 4'b0011, 1'b0);
    issue(1'b0, 32'h104, 32'd0, 4'd0, 1'b0);          // hit with merged low half
    issue(1'b0, 32'h100 + (32'd1 << TAG_LO), 32'd0, 4'd0, 1'b0);  // conflict miss
    issue(1'b0, 32'h100, 32'd0, 4'd0, 1'b0);          // evicted, misses again
    issue(1'b0, 32'h10C, 32'd0, 4'd0, 1'b1);          // hit; then a poked miss below
    issue(1'b0, 32'h208, 32'd0, 4'd0, 1'b1);          // miss with enable pulsed while busy
    issue(1'b1, 32'h208, 32'h1234_5678, 4'b1100, 1'b1);

    // Reset in the middle of a fill after two beats
    ack_budget = 2;
    a0 = acks_seen;
    for (int k = 0; k < BEATS; k++)
      exp_beat_q.push_back('{we: 1'b0, addr: 32'h900 + 32'(4 * k), data: 32'd0, sel: 4'd0});
    dcache_enable = 1'b1;
    dcache_we     = 1'b0;
    dcache_addr   = 32'h900;
    @(negedge CLK);
    dcache_enable = 1'b0;
    check("abort_busy", 32'(dcache_busy), 32'd1);
    for (int c = 0; c < 200 && (acks_seen - a0) < 2; c++) @(negedge CLK);
    check("abort_acks", 32'(acks_seen - a0), 32'd2);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    check("abort_busy_clr", 32'(dcache_busy), 32'd0);
    check("abort_req_clr", 32'(mem_req), 32'd0);
    exp_beat_q.delete();
    clear_ref_valid();
    ack_budget = -1;
    issue(1'b0, 32'h100, 32'd0, 4'd0, 1'b0);          // miss again after reset

    // Reset together with enable: command dropped
    rst           = 1'b1;
    dcache_enable = 1'b1;
    dcache_we     = 1'b0;
    dcache_addr   = 32'h700;
    @(negedge CLK);
    rst           = 1'b0;
    dcache_enable = 1'b0;
    clear_ref_valid();
    check("rst_en_busy", 32'(dcache_busy), 32'd0);
    repeat (3) @(negedge CLK);
    check("rst_en_no_req", 32'(mem_req), 32'd0);

    // Randomized traffic over a small, conflict-heavy address set
    for (int n = 0; n < 250; n++) begin
      ra = (32'($urandom_range(0, 3)) << TAG_LO) |
           (32'($urandom_range(14, 17)) << IDX_LO) |
           (32'($urandom_range(0, BEATS - 1)) << 2) |
           32'($urandom_range(0, 3));
      issue(($urandom_range(0, 9) < 3), ra, $urandom, 4'($urandom),
            ($urandom_range(0, 9) == 0));
    end

    repeat (4) @(negedge CLK);
    check("beat_q_empty", 32'(exp_beat_q.size()), 32'd0);
    check("load_q_empty", 32'(exp_load_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
